// File: rtl/led_nixie_monitor_pkg.sv
// Shared codes for the nixie bus monitor: controller state codes, segment
// patterns, COM slot codes, dp classes, and the decode/map helpers.
package led_nixie_monitor_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SUN     = 3'd1;
    localparam logic [2:0] ST_YELLOW  = 3'd2;
    localparam logic [2:0] ST_WHITE   = 3'd3;
    localparam logic [2:0] ST_WAITSUN = 3'd4;
    localparam logic [2:0] ST_WAITYLW = 3'd5;
    localparam logic [2:0] ST_WAITWHT = 3'd6;

    localparam logic [6:0] SEG_D0 = 7'h7E;
    localparam logic [6:0] SEG_D1 = 7'h30;
    localparam logic [6:0] SEG_D2 = 7'h6D;
    localparam logic [6:0] SEG_D3 = 7'h79;
    localparam logic [6:0] SEG_D4 = 7'h33;
    localparam logic [6:0] SEG_D5 = 7'h5B;
    localparam logic [6:0] SEG_D6 = 7'h5F;
    localparam logic [6:0] SEG_D7 = 7'h70;
    localparam logic [6:0] SEG_D8 = 7'h7F;
    localparam logic [6:0] SEG_D9 = 7'h7B;

    localparam logic [1:0] COM_BLANK   = 2'b00;
    localparam logic [1:0] COM_TENS    = 2'b01;
    localparam logic [1:0] COM_UNITS   = 2'b10;
    localparam logic [1:0] COM_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        DP_OFF   = 2'd0,
        DP_ON    = 2'd1,
        DP_BLINK = 2'd2
    } dp_class_e;

    // Returns {legal, bcd}
    function automatic logic [4:0] seg_decode(input logic [6:0] pat);
        case (pat)
            SEG_D0:  seg_decode = {1'b1, 4'd0};
            SEG_D1:  seg_decode = {1'b1, 4'd1};
            SEG_D2:  seg_decode = {1'b1, 4'd2};
            SEG_D3:  seg_decode = {1'b1, 4'd3};
            SEG_D4:  seg_decode = {1'b1, 4'd4};
            SEG_D5:  seg_decode = {1'b1, 4'd5};
            SEG_D6:  seg_decode = {1'b1, 4'd6};
            SEG_D7:  seg_decode = {1'b1, 4'd7};
            SEG_D8:  seg_decode = {1'b1, 4'd8};
            SEG_D9:  seg_decode = {1'b1, 4'd9};
            default: seg_decode = {1'b0, 4'd0};
        endcase
    endfunction

    // Returns {legal, state} for a (tens, units) dp class pair
    function automatic logic [3:0] dp_map(input dp_class_e tens, input dp_class_e units);
        case ({tens, units})
            {DP_OFF,   DP_OFF}:   dp_map = {1'b1, ST_IDLE};
            {DP_ON,    DP_ON}:    dp_map = {1'b1, ST_SUN};
            {DP_ON,    DP_OFF}:   dp_map = {1'b1, ST_YELLOW};
            {DP_OFF,   DP_ON}:    dp_map = {1'b1, ST_WHITE};
            {DP_OFF,   DP_BLINK}: dp_map = {1'b1, ST_WAITSUN};
            {DP_BLINK, DP_BLINK}: dp_map = {1'b1, ST_WAITYLW};
            {DP_BLINK, DP_OFF}:   dp_map = {1'b1, ST_WAITWHT};
            default:              dp_map = {1'b0, ST_IDLE};
        endcase
    endfunction

endpackage

// File: rtl/nixie_seg_capture.sv
// Synchronizes the {COM,SEG} bus and emits one capture strobe per value that
// stays unchanged for STABLE_CYC consecutive samples.
module nixie_seg_capture #(
    parameter int STABLE_CYC = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_com,
    input  logic [7:0] i_seg,
    output logic [1:0] o_com,
    output logic [7:0] o_seg,
    output logic       o_stb
);
    localparam int            CW   = (STABLE_CYC > 2) ? $clog2(STABLE_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYC - 1);

    logic [9:0]    r_sync_p0;
    logic [9:0]    r_sync_p1;
    logic [9:0]    r_prev;
    logic [CW-1:0] r_cnt;
    logic          r_stb;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync_p0 <= '0;
            r_sync_p1 <= '0;
            r_prev    <= '0;
            r_cnt     <= '0;
            r_stb     <= 1'b0;
        end else begin
            r_sync_p0 <= {i_com, i_seg};
            r_sync_p1 <= r_sync_p0;
            r_stb     <= 1'b0;
            // Counter parks at LAST so a held value is captured only once
            if (r_sync_p1 != r_prev) begin
                r_prev <= r_sync_p1;
                r_cnt  <= '0;
            end else if (r_cnt != LAST) begin
                r_cnt <= r_cnt + 1'b1;
                r_stb <= (r_cnt == LAST - 1'b1);
            end
        end
    end

    assign o_com = r_prev[9:8];
    assign o_seg = r_prev[7:0];
    assign o_stb = r_stb;

endmodule

// File: rtl/led_nixie_monitor.sv
// Receive-side decoder for the two-digit multiplexed nixie bus: recovers the BCD
// digits and the light-controller state from decimal-point patterns per window.
module led_nixie_monitor
    import led_nixie_monitor_pkg::*;
#(
    parameter int STABLE_CYC   = 16,
    parameter int WINDOW_SCANS = 6000,
    parameter int CNT_W        = 13
) (
    input  logic       Sys_CLK,
    input  logic       Sys_RST,
    input  logic [1:0] COM,
    input  logic [7:0] SEG,
    output logic [3:0] units_bcd,
    output logic [3:0] tens_bcd,
    output logic       digit_valid,
    output logic [2:0] state_out,
    output logic       state_valid,
    output logic       seg_err,
    output logic       com_err,
    output logic       state_err
);
    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW_SCANS - 1);

    logic [1:0] w_cap_com;
    logic [7:0] w_cap_seg;
    logic       w_cap_stb;

    nixie_seg_capture #(.STABLE_CYC(STABLE_CYC)) u_capture (
        .i_clk (Sys_CLK),
        .i_rst (Sys_RST),
        .i_com (COM),
        .i_seg (SEG),
        .o_com (w_cap_com),
        .o_seg (w_cap_seg),
        .o_stb (w_cap_stb)
    );

    logic [3:0]       r_units_bcd, r_tens_bcd, w_units_bcd, w_tens_bcd;
    logic             r_units_ok, r_tens_ok, w_units_ok, w_tens_ok;
    logic             r_digit_valid, w_digit_valid;
    logic [2:0]       r_state, w_state;
    logic             r_state_valid, w_state_valid;
    logic             r_seg_err, r_com_err, r_state_err;
    logic             w_seg_err, w_com_err, w_state_err;
    logic [CNT_W-1:0] r_win_cnt, w_win_cnt;
    logic             r_u_seen, r_u_dp0, r_u_chg, w_u_seen, w_u_dp0, w_u_chg;
    logic             r_t_seen, r_t_dp0, r_t_chg, w_t_seen, w_t_dp0, w_t_chg;
    logic [4:0]       w_dec;
    logic [3:0]       w_map;
    logic             w_dp, w_win_end;

    function automatic dp_class_e classify(input logic chg, input logic first_dp);
        if (chg)
            classify = DP_BLINK;
        else if (first_dp)
            classify = DP_ON;
        else
            classify = DP_OFF;
    endfunction

    always_comb begin
        w_dec         = seg_decode(w_cap_seg[7:1]);
        w_dp          = w_cap_seg[0];
        w_units_bcd   = r_units_bcd;
        w_tens_bcd    = r_tens_bcd;
        w_units_ok    = r_units_ok;
        w_tens_ok     = r_tens_ok;
        w_state       = r_state;
        w_state_valid = r_state_valid;
        w_seg_err     = 1'b0;
        w_com_err     = 1'b0;
        w_state_err   = 1'b0;
        w_win_cnt     = r_win_cnt;
        w_win_end     = 1'b0;
        w_u_seen      = r_u_seen;
        w_u_dp0       = r_u_dp0;
        w_u_chg       = r_u_chg;
        w_t_seen      = r_t_seen;
        w_t_dp0       = r_t_dp0;
        w_t_chg       = r_t_chg;
        if (w_cap_stb) begin
            case (w_cap_com)
                COM_UNITS: begin
                    if (w_dec[4]) begin
                        w_units_bcd = w_dec[3:0];
                        w_units_ok  = 1'b1;
                    end else begin
                        w_seg_err  = 1'b1;
                        w_units_ok = 1'b0;
                    end
                    if (!r_u_seen) begin
                        w_u_seen = 1'b1;
                        w_u_dp0  = w_dp;
                    end else if (w_dp != r_u_dp0) begin
                        w_u_chg = 1'b1;
                    end
                    w_win_end = (r_win_cnt == WIN_LAST);
                    w_win_cnt = r_win_cnt + 1'b1;
                end
                COM_TENS: begin
                    if (w_dec[4]) begin
                        w_tens_bcd = w_dec[3:0];
                        w_tens_ok  = 1'b1;
                    end else begin
                        w_seg_err = 1'b1;
                        w_tens_ok = 1'b0;
                    end
                    if (!r_t_seen) begin
                        w_t_seen = 1'b1;
                        w_t_dp0  = w_dp;
                    end else if (w_dp != r_t_dp0) begin
                        w_t_chg = 1'b1;
                    end
                end
                COM_BLANK: begin
                    w_units_ok    = 1'b0;
                    w_tens_ok     = 1'b0;
                    w_state_valid = 1'b0;
                    w_win_cnt     = '0;
                    w_u_seen      = 1'b0;
                    w_u_chg       = 1'b0;
                    w_t_seen      = 1'b0;
                    w_t_chg       = 1'b0;
                end
                COM_ILLEGAL: w_com_err = 1'b1;
            endcase
        end
        // Closing units capture is already folded into w_u_*; a window with no tens capture is unmapped
        w_map = dp_map(classify(r_t_chg, r_t_dp0), classify(w_u_chg, w_u_dp0));
        if (w_win_end) begin
            if (r_t_seen && w_map[3]) begin
                w_state       = w_map[2:0];
                w_state_valid = 1'b1;
            end else begin
                w_state_err   = 1'b1;
                w_state_valid = 1'b0;
            end
            w_win_cnt = '0;
            w_u_seen  = 1'b0;
            w_u_chg   = 1'b0;
            w_t_seen  = 1'b0;
            w_t_chg   = 1'b0;
        end
        w_digit_valid = w_units_ok & w_tens_ok;
    end

    always_ff @(posedge Sys_CLK or posedge Sys_RST) begin
        if (Sys_RST) begin
            r_units_bcd   <= '0;
            r_tens_bcd    <= '0;
            r_units_ok    <= 1'b0;
            r_tens_ok     <= 1'b0;
            r_digit_valid <= 1'b0;
            r_state       <= ST_IDLE;
            r_state_valid <= 1'b0;
            r_seg_err     <= 1'b0;
            r_com_err     <= 1'b0;
            r_state_err   <= 1'b0;
            r_win_cnt     <= '0;
            r_u_seen      <= 1'b0;
            r_u_dp0       <= 1'b0;
            r_u_chg       <= 1'b0;
            r_t_seen      <= 1'b0;
            r_t_dp0       <= 1'b0;
            r_t_chg       <= 1'b0;
        end else begin
            r_units_bcd   <= w_units_bcd;
            r_tens_bcd    <= w_tens_bcd;
            r_units_ok    <= w_units_ok;
            r_tens_ok     <= w_tens_ok;
            r_digit_valid <= w_digit_valid;
            r_state       <= w_state;
            r_state_valid <= w_state_valid;
            r_seg_err     <= w_seg_err;
            r_com_err     <= w_com_err;
            r_state_err   <= w_state_err;
            r_win_cnt     <= w_win_cnt;
            r_u_seen      <= w_u_seen;
            r_u_dp0       <= w_u_dp0;
            r_u_chg       <= w_u_chg;
            r_t_seen      <= w_t_seen;
            r_t_dp0       <= w_t_dp0;
            r_t_chg       <= w_t_chg;
        end
    end

    assign units_bcd   = r_units_bcd;
    assign tens_bcd    = r_tens_bcd;
    assign digit_valid = r_digit_valid;
    assign state_out   = r_state;
    assign state_valid = r_state_valid;
    assign seg_err     = r_seg_err;
    assign com_err     = r_com_err;
    assign state_err   = r_state_err;

endmodule

// File: doc/led_nixie_monitor.md
Name: led_nixie_monitor

Overview:
Receive-side decoder for the two-digit multiplexed LED nixie-tube bus (COM[1:0], SEG[7:0]) driven by the display driver. It recovers the two BCD digits and the light-controller state from the decimal-point patterns. It serves as on-chip self-check and readback, sitting beside the display driver on the same pins.

Parameters:
STABLE_CYC, 16, consecutive identical Sys_CLK samples of {COM,SEG} required before a capture (glitch/ghost filter)
WINDOW_SCANS, 6000, units-slot captures per dp classification window (must exceed one dp half-period, 2501 scans)
CNT_W, 13, width of the window counter (ceil(log2(WINDOW_SCANS+1)))

Ports:
Sys_CLK  in  1  system clock
Sys_RST  in  1  asynchronous, active-high reset
COM  in  2  digit select: 2'b10 = units, 2'b01 = tens, 2'b00 = blank, 2'b11 = illegal
SEG  in  8  SEG[7:1] = segments a..g (active high), SEG[0] = dp
units_bcd  out  4  last valid units digit
tens_bcd  out  4  last valid tens digit
digit_valid  out  1  both slots hold a legal code since the last blank or error
state_out  out  3  recovered controller state (0 IDLE, 1 SUN, 2 YELLOW, 3 WHITE, 4 WAITSUN, 5 WAITYLW, 6 WAITWHT)
state_valid  out  1  state_out derived from a complete, legal window
seg_err  out  1  one-cycle pulse: captured segment pattern is not 0-9
com_err  out  1  one-cycle pulse: COM == 2'b11 captured
state_err  out  1  one-cycle pulse: window ended with an unmapped dp combination

Behaviour:
- Reset (asynchronous): all outputs 0, state_out = IDLE, all counters and slot registers cleared. Reset mid-window discards the window.
- Input path: 2-FF synchronizer on COM and SEG (10 bits). The stability counter increments while the synced value equals the previous sample and restarts at 0 on any change. Exactly one capture strobe fires when the count reaches STABLE_CYC-1. Capture latency is STABLE_CYC+2 cycles after a pin change. No further strobe fires until the next change.
- Segment decode of SEG[7:1], in hex: 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70, 8=7F, 9=7B. Any other pattern is illegal.
- Capture with COM=10 or 01: a legal code writes units_bcd or tens_bcd and sets that slot's ok flag. An illegal code pulses seg_err, clears the slot's ok flag and leaves its bcd unchanged.
- Capture with COM=00 (blank): both ok flags cleared, window reset, state_valid <= 0. state_out is held.
- Capture with COM=11: com_err pulse only. Nothing else changes.
- digit_valid = units_ok & tens_ok, registered. It updates 1 cycle after the capture strobe.
- dp tracking, per slot: the first dp of the window is stored as ref, and a changed flag is set if any later capture differs from ref.
- The window counter increments on each units capture. When it reaches WINDOW_SCANS:
  - Each slot classifies as BLINK if changed, otherwise ON or OFF from ref.
  - The counter and flags reset in the same cycle.
  - A tens capture coinciding with the window end belongs to the new window.
- State map, (tens, units) -> state:
  - (OFF, OFF) -> IDLE
  - (ON, ON) -> SUN
  - (ON, OFF) -> YELLOW
  - (OFF, ON) -> WHITE
  - (OFF, BLINK) -> WAITSUN
  - (BLINK, BLINK) -> WAITYLW
  - (BLINK, OFF) -> WAITWHT
  - Anything else: state_err pulse, state_valid <= 0, state_out held.
- On a legal map: state_out and state_valid=1 update 1 cycle after the window end.
- A window with zero tens captures counts as an unmapped combination (state_err).

Decomposition:
- Shared package: 7-state codes (IDLE..WAITWHT), the ten segment constants, COM slot codes, and the dp class enum (OFF, ON, BLINK).
- One sub-module, nixie_seg_capture: synchronizer, stability counter and capture strobe, outputting {com, seg} plus a strobe.
- The parent holds the segment decode, slot registers, dp window and state mapping.

Test Plan:
- Alternate COM 10/01 every 200 cycles, SEG 7B (units) and 30 (tens) -> units_bcd=9, tens_bcd=1, digit_valid=1; no error pulses.
- 3-cycle glitch SEG=00 inside a stable 7E phase -> no capture, no seg_err, digits unchanged.
- Units phase SEG=0x4A -> seg_err single pulse, digit_valid=0; next legal units capture restores digit_valid=1.
- dp units constant 1, tens constant 0, one full window -> state_out=3 (WHITE), state_valid=1.
- dp units toggling every 2500 scans, tens 0 -> state_out=4 (WAITSUN); both toggling -> 5 (WAITYLW).
- Tens BLINK with units ON -> state_err pulse, state_valid=0, state_out held; COM=11 -> com_err. Assert Sys_RST mid-window -> all outputs 0 immediately.
